// File: rtl/dcache_sram_port.sv
// dcache_sram_port: banked byte-masked SRAM with pipelined reads and a credit-guarded in-order response FIFO
module dcache_sram_port #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 13,
    parameter int NUM_BANKS    = 4,
    parameter int READ_LATENCY = 2,
    parameter int RSP_DEPTH    = 4,
    parameter bit IZERO        = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_wmask_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    busy_o
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int LB     = $clog2(NUM_BANKS);
    localparam int BW     = LB > 0 ? LB : 1;
    localparam int ROWS   = (1 << ADDR_WIDTH) / NUM_BANKS;
    localparam int RW     = ADDR_WIDTH - LB > 0 ? ADDR_WIDTH - LB : 1;
    localparam int CW     = $clog2(RSP_DEPTH + 1);
    localparam int PW     = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
    localparam logic [DATA_WIDTH-1:0] INIT = IZERO ? {DATA_WIDTH{1'b0}} : {DATA_WIDTH{1'bx}};

    // Storage has no reset; the initial value only matters when IZERO is set
    logic [DATA_WIDTH-1:0]   mem_q [NUM_BANKS][ROWS] = '{default: '{default: INIT}};
    logic [DATA_WIDTH-1:0]   pd_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   fifo_q [RSP_DEPTH];
    logic [READ_LATENCY-1:0] pv_q, pv_d;
    logic [PW-1:0]           wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]           cnt_q, cnt_d, out_q, out_d;
    logic                    en_q;
    logic [BW-1:0]           bank;
    logic [RW-1:0]           row;
    logic                    acc_rd, acc_wr, push, pop;

    // Address split, handshakes and visible status
    always_comb begin
        bank        = BW'(req_addr_i & ADDR_WIDTH'(NUM_BANKS - 1));
        row         = RW'(req_addr_i >> LB);
        req_ready_o = en_q && (out_q < CW'(RSP_DEPTH));
        acc_rd      = req_valid_i && req_ready_o && !req_we_i;
        acc_wr      = req_valid_i && req_ready_o && req_we_i;
        push        = pv_q[READ_LATENCY-1];
        rsp_valid_o = cnt_q != '0;
        pop         = rsp_valid_o && rsp_ready_i;
        rsp_rdata_o = rsp_valid_o ? fifo_q[rp_q] : '0;
        busy_o      = out_q != '0;
    end

    // Byte-masked write into the selected bank; an all-zero mask leaves storage untouched
    always_ff @(posedge clk_i) begin
        if (acc_wr) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (req_wmask_i[i]) mem_q[bank][row][i*8 +: 8] <= req_wdata_i[i*8 +: 8];
            end
        end
    end

    // Read data pipeline: stage 0 samples storage at accept, later stages shift; FIFO captures the last stage
    always_ff @(posedge clk_i) begin
        pd_q[0] <= mem_q[bank][row];
        for (int i = 1; i < READ_LATENCY; i++) pd_q[i] <= pd_q[i-1];
        if (push) fifo_q[wp_q] <= pd_q[READ_LATENCY-1];
    end

    // Next state for valid pipeline, FIFO pointers/occupancy and read credits
    always_comb begin
        pv_d  = READ_LATENCY'({pv_q, acc_rd});
        wp_d  = push ? ((wp_q == PW'(RSP_DEPTH - 1)) ? '0 : wp_q + PW'(1)) : wp_q;
        rp_d  = pop ? ((rp_q == PW'(RSP_DEPTH - 1)) ? '0 : rp_q + PW'(1)) : rp_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        out_d = out_q + CW'(acc_rd) - CW'(pop);
    end

    // Control state; reset drops every in-flight and buffered read
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pv_q  <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            out_q <= '0;
            en_q  <= 1'b0;
        end else begin
            pv_q  <= pv_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
            en_q  <= 1'b1;
        end
    end
endmodule
